// File: rtl/param_deserializer.sv
// Serial-to-parallel deserializer with per-frame length, flush of partial
// frames, and selectable bit order. Output word and length are registered.
module param_deserializer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MSB_FIRST = 1,
  localparam int unsigned CNT_W    = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [CNT_W-1:0]  deser_len_o,
  output logic              deser_data_val_o
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0]  eff_len, eff_n, eff_in;
  logic [CNT_W-1:0]  bit_idx;
  int unsigned       bit_pos;
  logic              take, emit;

  always_comb begin
    eff_in  = (len_i == '0 || len_i > FULL) ? FULL : len_i;
    cnt_inc = (cnt >= FULL) ? FULL : cnt + ONE;
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (data_val_i && !emit) state_n = COLLECT;
      COLLECT: if (emit) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The first bit of a frame clears the word, so unfilled positions read 0
  // and a flush arriving with that bit has no effect.
  always_comb begin
    shreg_n = shreg;
    cnt_n   = cnt;
    eff_n   = eff_len;
    bit_idx = cnt;
    take    = 1'b0;
    emit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_val_i) begin
          shreg_n = '0;
          eff_n   = eff_in;
          bit_idx = '0;
          take    = 1'b1;
          cnt_n   = ONE;
          emit    = (eff_in == ONE);
        end
      end
      COLLECT: begin
        if (data_val_i) begin
          take  = 1'b1;
          cnt_n = cnt_inc;
        end
        emit = flush_i || (data_val_i && cnt_inc >= eff_len);
      end
      default: ;
    endcase
    bit_pos = (MSB_FIRST != 0) ? (DATA_W - 1 - 32'(bit_idx)) : 32'(bit_idx);
    if (take) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (i == bit_pos) shreg_n[i] = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      shreg            <= '0;
      cnt              <= '0;
      eff_len          <= FULL;
      deser_data_o     <= '0;
      deser_len_o      <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      shreg            <= shreg_n;
      eff_len          <= eff_n;
      deser_data_val_o <= emit;
      if (emit) begin
        cnt          <= '0;
        deser_data_o <= shreg_n;
        deser_len_o  <= cnt_n;
      end else begin
        cnt <= cnt_n;
      end
    end
  end

endmodule

// File: tb/tb_param_deserializer.sv
// Bench for param_deserializer: MSB-first and LSB-first instances share one
// stimulus stream and are compared against a queue-based frame model.
module tb_param_deserializer;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b0;
  logic        data_i = 1'b0;
  logic        data_val_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [4:0]  len_i = '0;
  logic [15:0] data_m, data_l;
  logic [4:0]  len_m, len_l;
  logic        val_m, val_l;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          q[$];
  int          eff = 0;
  logic        exp_val = 1'b0;
  logic [4:0]  exp_len = '0;
  logic [15:0] exp_msb = '0;
  logic [15:0] exp_lsb = '0;

  param_deserializer #(.DATA_W(16), .MSB_FIRST(1)) dut_m (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .len_i(len_i), .flush_i(flush_i), .deser_data_o(data_m),
    .deser_len_o(len_m), .deser_data_val_o(val_m)
  );

  param_deserializer #(.DATA_W(16), .MSB_FIRST(0)) dut_l (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .len_i(len_i), .flush_i(flush_i), .deser_data_o(data_l),
    .deser_len_o(len_l), .deser_data_val_o(val_l)
  );

  always #5 clk_i = ~clk_i;

  function automatic void model_emit();
    exp_msb = '0;
    exp_lsb = '0;
    foreach (q[k]) begin
      exp_msb[15-k] = q[k];
      exp_lsb[k]    = q[k];
    end
    exp_len = 5'(q.size());
    exp_val = 1'b1;
    q.delete();
  endfunction

  function automatic void model_reset();
    q.delete();
    exp_val = 1'b0;
    exp_len = '0;
    exp_msb = '0;
    exp_lsb = '0;
  endfunction

  // Drive one cycle, advance the model across the edge, return #1 after it.
  task automatic step(input logic v, input logic d, input logic [4:0] l, input logic f);
    data_val_i = v;
    data_i     = d;
    len_i      = l;
    flush_i    = f;
    @(posedge clk_i);
    cyc++;
    exp_val = 1'b0;
    if (q.size() == 0) begin
      if (v) begin
        eff = (l == 0 || l > 16) ? 16 : int'(l);
        q.push_back(d);
        if (eff == 1) model_emit();
      end
    end else begin
      if (v) q.push_back(d);
      if (f || q.size() == eff) model_emit();
    end
    #1;
  endtask

  task automatic test_reset();
    #1 srst_i = 1'b1;
    #2;
    model_reset();
    checks++;
    if ({val_m, len_m, data_m, val_l, len_l, data_l} !== 43'd0) begin
      errors++;
      $display("FAIL reset_values: got m val=%b len=%0d data=%h l val=%b len=%0d data=%h, expected all 0",
               val_m, len_m, data_m, val_l, len_l, data_l);
    end
    @(posedge clk_i);
    #1 srst_i = 1'b0;
  endtask

  task automatic test_full_word();
    logic [15:0] w = 16'hA5C3;
    for (int i = 0; i < 17; i++) begin
      step(i < 16, (i < 16) ? w[15-i] : 1'b0, 5'd0, 1'b0);
      checks++;
      if ({val_m, len_m, data_m, val_l, len_l, data_l} !== {exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb}) begin
        errors++;
        $display("FAIL full_word cyc=%0d: got m %b/%0d/%h l %b/%0d/%h, expected m %b/%0d/%h l %b/%0d/%h",
                 cyc, val_m, len_m, data_m, val_l, len_l, data_l, exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb);
      end
      if (i == 15) begin
        checks++;
        if (val_m !== 1'b1 || data_m !== 16'hA5C3 || len_m !== 5'd16) begin
          errors++;
          $display("FAIL full_word_a5c3: got val=%b data=%h len=%0d, expected 1 a5c3 16", val_m, data_m, len_m);
        end
      end
    end
  endtask

  task automatic test_lsb_mode();
    logic b[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b[i], 5'd4, 1'b0);
      checks++;
      if ({val_m, len_m, data_m, val_l, len_l, data_l} !== {exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb}) begin
        errors++;
        $display("FAIL lsb_mode cyc=%0d: got m %b/%0d/%h l %b/%0d/%h, expected m %b/%0d/%h l %b/%0d/%h",
                 cyc, val_m, len_m, data_m, val_l, len_l, data_l, exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb);
      end
    end
    checks++;
    if (val_l !== 1'b1 || data_l !== 16'h000D || len_l !== 5'd4 || data_m !== 16'hB000) begin
      errors++;
      $display("FAIL lsb_000d: got val=%b data_l=%h len=%0d data_m=%h, expected 1 000d 4 b000", val_l, data_l, len_l, data_m);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] fw = 32'h1234_FFFF;
    int pc[$];
    logic [15:0] pd[$];
    for (int i = 0; i < 32; i++) begin
      step(1'b1, fw[31-i], 5'd0, 1'b0);
      if (val_m === 1'b1) begin
        pc.push_back(cyc);
        pd.push_back(data_m);
      end
      checks++;
      if ({val_m, len_m, data_m, val_l, len_l, data_l} !== {exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb}) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d: got m %b/%0d/%h l %b/%0d/%h, expected m %b/%0d/%h l %b/%0d/%h",
                 cyc, val_m, len_m, data_m, val_l, len_l, data_l, exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb);
      end
    end
    checks++;
    if (pc.size() != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d pulses, expected 2", pc.size());
    end else if (pc[1] - pc[0] != 16 || pd[0] !== 16'h1234 || pd[1] !== 16'hFFFF) begin
      errors++;
      $display("FAIL b2b_spacing: got gap=%0d data=%h,%h, expected 16 1234,ffff", pc[1] - pc[0], pd[0], pd[1]);
    end
  endtask

  task automatic test_gaps_flush();
    logic b[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g <= gap; g++) begin
        if (g < gap)     step(1'b0, 1'($urandom), 5'd0, 1'b0);
        else if (i < 5)  step(1'b1, b[i], 5'd0, 1'b0);
        else             step(1'b0, 1'($urandom), 5'd0, 1'b1);
        checks++;
        if ({val_m, len_m, data_m, val_l, len_l, data_l} !== {exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb}) begin
          errors++;
          $display("FAIL gaps_flush cyc=%0d: got m %b/%0d/%h l %b/%0d/%h, expected m %b/%0d/%h l %b/%0d/%h",
                   cyc, val_m, len_m, data_m, val_l, len_l, data_l, exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb);
        end
      end
    end
    checks++;
    if (val_m !== 1'b1 || data_m !== 16'hC800 || len_m !== 5'd5 || data_l !== 16'h0013) begin
      errors++;
      $display("FAIL flush_c800: got val=%b data_m=%h len=%0d data_l=%h, expected 1 c800 5 0013", val_m, data_m, len_m, data_l);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w = 16'h0001;
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 5'd0, 1'b0);
    srst_i     = 1'b1;
    data_val_i = 1'b1;
    #2;
    model_reset();
    checks++;
    if ({val_m, len_m, data_m, val_l, len_l, data_l} !== 43'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got m %b/%0d/%h l %b/%0d/%h, expected all 0", val_m, len_m, data_m, val_l, len_l, data_l);
    end
    @(posedge clk_i);
    #1 srst_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) step(1'b0, 1'b1, 5'd0, 1'b1);
      else       step(1'b1, w[15-(i-4)], 5'd0, 1'b0);
      checks++;
      if ({val_m, len_m, data_m, val_l, len_l, data_l} !== {exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb}) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d: got m %b/%0d/%h l %b/%0d/%h, expected m %b/%0d/%h l %b/%0d/%h",
                 cyc, val_m, len_m, data_m, val_l, len_l, data_l, exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb);
      end
    end
    checks++;
    if (val_m !== 1'b1 || data_m !== 16'h0001 || len_m !== 5'd16) begin
      errors++;
      $display("FAIL reset_then_0001: got val=%b data=%h len=%0d, expected 1 0001 16", val_m, data_m, len_m);
    end
  endtask

  task automatic test_len_bounds();
    logic v;
    for (int i = 0; i < 20; i++) begin
      v = ($urandom % 3) != 0;
      step(v, 1'($urandom), 5'd1, 1'b0);
      checks++;
      if (val_m !== v || {val_l, len_l, data_l} !== {exp_val, exp_len, exp_lsb} || (v && len_m !== 5'd1)) begin
        errors++;
        $display("FAIL len1 cyc=%0d: got val=%b len=%0d data_l=%h, expected val=%b len=1 data_l=%h", cyc, val_m, len_m, data_l, v, exp_lsb);
      end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'($urandom), 5'd20, 1'b0);
      checks++;
      if ({val_m, len_m, data_m, val_l, len_l, data_l} !== {exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb}) begin
        errors++;
        $display("FAIL len20 cyc=%0d: got m %b/%0d/%h l %b/%0d/%h, expected m %b/%0d/%h l %b/%0d/%h",
                 cyc, val_m, len_m, data_m, val_l, len_l, data_l, exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb);
      end
    end
    checks++;
    if (val_m !== 1'b1 || len_m !== 5'd16) begin
      errors++;
      $display("FAIL len20_as_16: got val=%b len=%0d, expected 1 16", val_m, len_m);
    end
    step(1'b1, 1'b1, 5'd3, 1'b1);
    step(1'b1, 1'b0, 5'd3, 1'b0);
    step(1'b1, 1'b1, 5'd3, 1'b1);
    checks++;
    if (val_m !== 1'b1 || len_m !== 5'd3 || data_m !== 16'hA000 || data_l !== 16'h0005) begin
      errors++;
      $display("FAIL flush_edges: got val=%b len=%0d data_m=%h data_l=%h, expected 1 3 a000 0005", val_m, len_m, data_m, data_l);
    end
    step(1'b0, 1'b0, 5'd3, 1'b0);
    checks++;
    if (val_m !== 1'b0 || data_m !== 16'hA000) begin
      errors++;
      $display("FAIL single_pulse: got val=%b data=%h, expected 0 a000", val_m, data_m);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 4) != 0, 1'($urandom), 5'($urandom_range(0, 31)), ($urandom % 6) == 0);
      checks++;
      if ({val_m, len_m, data_m, val_l, len_l, data_l} !== {exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb}) begin
        errors++;
        $display("FAIL random cyc=%0d: got m %b/%0d/%h l %b/%0d/%h, expected m %b/%0d/%h l %b/%0d/%h",
                 cyc, val_m, len_m, data_m, val_l, len_l, data_l, exp_val, exp_len, exp_msb, exp_val, exp_len, exp_lsb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_lsb_mode();
    test_back_to_back();
    test_gaps_flush();
    test_reset_mid_frame();
    test_len_bounds();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_deserializer.md
PARAM_DESERIALIZER -- requirements
Module: param_deserializer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, output word width in bits; legal range 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit goes to the MSB, 0 = first received bit goes to bit 0.
REQ-003 SHALL derive local parameter CNT_W = $clog2(DATA_W+1), the width of the bit-count fields.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports clk_i and srst_i as listed in REQ-005 and REQ-006.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 srst_i  input  1  reset, asynchronous, active-high.
REQ-007 data_i  input  1  serial data bit.
REQ-008 data_val_i  input  1  qualifies data_i for this cycle.
REQ-009 len_i  input  CNT_W  frame length in bits; sampled only with the first bit of a frame.
REQ-010 flush_i  input  1  closes the current partial frame.
REQ-011 deser_data_o  output  DATA_W  assembled word.
REQ-012 deser_len_o  output  CNT_W  number of valid bits in deser_data_o.
REQ-013 deser_data_val_o  output  1  one-cycle pulse marking deser_data_o and deser_len_o as new.

Function
REQ-014 SHALL implement states IDLE (no bits held) and COLLECT (1..DATA_W-1 bits held).
REQ-015 IDLE with data_val_i=1 SHALL latch the effective length, store data_i as bit index 0 and set the count to 1.
REQ-016 IDLE with data_val_i=1 SHALL go to COLLECT, or emit immediately if the effective length is 1.
REQ-017 The effective length SHALL be DATA_W when len_i is 0 or greater than DATA_W, and len_i otherwise.
REQ-018 Each accepted bit with index k SHALL go to position DATA_W-1-k when MSB_FIRST=1, and to position k when MSB_FIRST=0.
REQ-019 Positions not filled in a frame SHALL read 0 in deser_data_o.
REQ-020 When the count reaches the effective length, the block SHALL copy the word and count to the output registers, pulse deser_data_val_o, and return to IDLE.
REQ-021 Latency SHALL be exactly 1 cycle: deser_data_val_o is high in the cycle after the clock edge that accepted the last bit.
REQ-022 deser_data_val_o SHALL be high for exactly one cycle per emitted frame.
REQ-023 deser_data_o and deser_len_o SHALL hold their values until the next emission.
REQ-024 There SHALL be no dead cycle: data_val_i in the cycle where deser_data_val_o is high is accepted as bit 0 of the next frame.
REQ-025 Back-to-back frames SHALL sustain 1 bit per clock with no bit lost.
REQ-026 flush_i in COLLECT SHALL emit the partial frame with deser_len_o equal to the bits held and return to IDLE.
REQ-027 flush_i together with data_val_i in COLLECT SHALL include that bit before emitting.
REQ-028 flush_i in IDLE SHALL be ignored; a flush that coincides with a frame's first bit is ignored, and the frame completes normally.
REQ-029 When a flush coincides with reaching the effective length, the block SHALL emit once.
REQ-030 Cycles with data_val_i=0 SHALL leave all state unchanged, except for flush handling.
REQ-031 Every internal bit counter SHALL saturate at DATA_W and never wrap; arithmetic SHALL use widths of at least CNT_W.

Reset
REQ-032 srst_i assertion SHALL immediately set deser_data_o=0, deser_len_o=0, deser_data_val_o=0, state=IDLE, and count=0.
REQ-033 A frame in progress when srst_i asserts SHALL be discarded; no partial emission.
REQ-034 After srst_i deasserts, the first accepted bit SHALL start a new frame.

Verification
REQ-035 Full word (DATA_W=16, MSB_FIRST=1, len_i=0): send bits of 0xA5C3 MSB first -> one pulse, deser_data_o=0xA5C3, deser_len_o=16, 1 cycle after the last bit.
REQ-036 LSB mode (MSB_FIRST=0, len_i=4): send bits 1,0,1,1 -> deser_data_o=0x000D, deser_len_o=4.
REQ-037 Back-to-back: two 16-bit frames, 0x1234 then 0xFFFF, data_val_i held high for 32 cycles -> two pulses exactly 16 cycles apart, values correct.
REQ-038 Gaps plus flush (len_i=0, MSB_FIRST=1): send 5 bits 1,1,0,0,1 with random data_val_i gaps, then flush_i alone -> deser_data_o=0xC800, deser_len_o=5.
REQ-039 Reset mid-frame: assert srst_i after 7 bits -> outputs 0 and no pulse; then send a full 0x0001 frame -> deser_data_o=0x0001.
REQ-040 Boundaries: len_i=1 -> a pulse every accepted bit; len_i=20 with DATA_W=16 -> treated as 16.
